// File: rtl/clock_pkg.sv
// Shared definitions for the BCD timekeeper: time-word field layout,
// BCD digit limits, and the sync-word validation helper.
package clock_pkg;

  localparam int DIGIT_W   = 4;

  // Time-word field positions
  localparam int MIN_U_LSB = 0;
  localparam int MIN_T_LSB = 4;
  localparam int HR_U_LSB  = 8;
  localparam int HR_T_LSB  = 12;
  localparam int COLOR_LSB = 16;
  localparam int COLOR_W   = 2;
  localparam int RSVD_LSB  = 18;
  localparam int RSVD_W    = 6;
  localparam int SEC_U_LSB = 24;
  localparam int SEC_T_LSB = 28;
  localparam int SEC_T_W   = 3;
  localparam int VALID_BIT = 31;

  // BCD limits
  localparam logic [DIGIT_W-1:0] BCD_MAX_UNITS   = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MAX_TENS    = 4'd5;
  localparam logic [DIGIT_W-1:0] BCD_MAX_HR_TENS = 4'd2;
  localparam int                 HOUR_LIMIT      = 23;
  localparam logic [DIGIT_W-1:0] HOUR_LIM_TENS   = 4'(HOUR_LIMIT / 10);
  localparam logic [DIGIT_W-1:0] HOUR_LIM_UNITS  = 4'(HOUR_LIMIT % 10);

  // Outcome of a sync strobe in the current cycle
  typedef enum logic [1:0] {
    SYNC_NONE   = 2'd0,
    SYNC_ACCEPT = 2'd1,
    SYNC_REJECT = 2'd2
  } sync_result_e;

  // Six time digits, each widened to a full BCD nibble
  typedef struct packed {
    logic [DIGIT_W-1:0] sec_t;
    logic [DIGIT_W-1:0] sec_u;
    logic [DIGIT_W-1:0] min_t;
    logic [DIGIT_W-1:0] min_u;
    logic [DIGIT_W-1:0] hr_t;
    logic [DIGIT_W-1:0] hr_u;
  } bcd_time_t;

  // True when every digit is in range and hours do not exceed 23
  function automatic logic bcd_time_ok(bcd_time_t t);
    logic ok;
    ok = (t.sec_u <= BCD_MAX_UNITS) && (t.sec_t <= BCD_MAX_TENS) &&
         (t.min_u <= BCD_MAX_UNITS) && (t.min_t <= BCD_MAX_TENS) &&
         (t.hr_u  <= BCD_MAX_UNITS) && (t.hr_t  <= BCD_MAX_HR_TENS) &&
         !((t.hr_t == HOUR_LIM_TENS) && (t.hr_u > HOUR_LIM_UNITS));
    return ok;
  endfunction

endpackage

// File: rtl/bcd_time_keeper_if.sv
// Sync input and time/pulse outputs between the HPS bridge and the timekeeper.
interface bcd_time_keeper_if;
  logic        sync_valid;
  logic [31:0] sync_time;
  logic [31:0] time_word;
  logic        sec_tick;
  logic        min_tick;
  logic        sync_ack;
  logic        sync_err;

  modport master (
    output sync_valid, sync_time,
    input  time_word, sec_tick, min_tick, sync_ack, sync_err
  );

  modport slave (
    input  sync_valid, sync_time,
    output time_word, sec_tick, min_tick, sync_ack, sync_err
  );
endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit: synchronous load, increment with programmable wrap value,
// and a combinational carry that fires when an increment wraps the digit.
module bcd_digit_counter
  import clock_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               inc,
  input  logic [DIGIT_W-1:0] max_val,
  output logic [DIGIT_W-1:0] q,
  output logic               carry_out
);

  logic [DIGIT_W-1:0] q_r;

  // Digit register: load beats increment; increment wraps at max_val
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_r <= 4'd0;
    end else if (load) begin
      q_r <= load_val;
    end else if (inc) begin
      q_r <= (q_r == max_val) ? 4'd0 : (q_r + 4'd1);
    end else begin
      q_r <= q_r;
    end
  end

  assign q         = q_r;
  assign carry_out = inc && (q_r == max_val);

endmodule

// File: rtl/bcd_time_keeper.sv
// Free-running BCD hh:mm:ss timekeeper resynchronised by HPS sync strobes.
// Priority per cycle: reset > accepted sync > second increment.
module bcd_time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  bcd_time_keeper_if.slave   tk
);

  localparam int                 PRESC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

  logic [PRESC_W-1:0] presc_r;
  logic [COLOR_W-1:0] color_r;
  logic               valid_r;
  logic               sec_tick_r;
  logic               min_tick_r;
  logic               sync_ack_r;
  logic               sync_err_r;

  bcd_time_t          sync_fields_s;
  sync_result_e       sync_res_s;
  logic               accept_s;
  logic               reject_s;
  logic               tc_s;
  logic               incr_s;
  logic               hour_wrap_s;
  logic               hr_load_s;
  logic [DIGIT_W-1:0] hr_u_ld_s;
  logic [DIGIT_W-1:0] hr_t_ld_s;

  logic [DIGIT_W-1:0] sec_u_s, sec_t_s, min_u_s, min_t_s, hr_u_s, hr_t_s;
  logic               sec_u_co_s, sec_t_co_s, min_u_co_s, min_t_co_s, hr_u_co_s;
  logic               hr_t_co_unused_s;
  logic               unused_bits_s;

  assign sync_fields_s = '{
    sec_t: {1'b0, tk.sync_time[SEC_T_LSB +: SEC_T_W]},
    sec_u: tk.sync_time[SEC_U_LSB +: DIGIT_W],
    min_t: tk.sync_time[MIN_T_LSB +: DIGIT_W],
    min_u: tk.sync_time[MIN_U_LSB +: DIGIT_W],
    hr_t:  tk.sync_time[HR_T_LSB  +: DIGIT_W],
    hr_u:  tk.sync_time[HR_U_LSB  +: DIGIT_W]
  };

  assign tc_s = (presc_r == PRESC_LAST);

  // Classify the sync strobe and decide whether this cycle counts a second
  always_comb begin
    sync_res_s = SYNC_NONE;
    if (tk.sync_valid) begin
      if (bcd_time_ok(sync_fields_s)) begin
        sync_res_s = SYNC_ACCEPT;
      end else begin
        sync_res_s = SYNC_REJECT;
      end
    end else begin
      sync_res_s = SYNC_NONE;
    end

    case (sync_res_s)
      SYNC_ACCEPT: begin accept_s = 1'b1; reject_s = 1'b0; end
      SYNC_REJECT: begin accept_s = 1'b0; reject_s = 1'b1; end
      default:     begin accept_s = 1'b0; reject_s = 1'b0; end
    endcase

    // An accepted sync swallows a coincident terminal count
    incr_s = tc_s && !accept_s;
  end

  // Hour pair: load on sync, or force 00 when counting past 23
  always_comb begin
    hour_wrap_s = min_t_co_s && (hr_t_s == HOUR_LIM_TENS) && (hr_u_s == HOUR_LIM_UNITS);
    hr_load_s   = accept_s || hour_wrap_s;
    if (accept_s) begin
      hr_u_ld_s = sync_fields_s.hr_u;
      hr_t_ld_s = sync_fields_s.hr_t;
    end else begin
      hr_u_ld_s = 4'd0;
      hr_t_ld_s = 4'd0;
    end
  end

  // Prescaler: restarts on accepted sync, wraps at terminal count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_r <= '0;
    end else if (accept_s || tc_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRESC_W'(1);
    end
  end

  // Colour and time-valid flag change only on an accepted sync
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      color_r <= 2'd0;
      valid_r <= 1'b0;
    end else if (accept_s) begin
      color_r <= tk.sync_time[COLOR_LSB +: COLOR_W];
      valid_r <= 1'b1;
    end else begin
      color_r <= color_r;
      valid_r <= valid_r;
    end
  end

  // One-cycle status pulses, aligned with the time update they describe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sec_tick_r <= 1'b0;
      min_tick_r <= 1'b0;
      sync_ack_r <= 1'b0;
      sync_err_r <= 1'b0;
    end else begin
      sec_tick_r <= incr_s;
      min_tick_r <= sec_t_co_s;
      sync_ack_r <= accept_s;
      sync_err_r <= reject_s;
    end
  end

  bcd_digit_counter u_sec_u (
    .clk(clk), .reset_n(reset_n), .load(accept_s), .load_val(sync_fields_s.sec_u),
    .inc(incr_s), .max_val(BCD_MAX_UNITS), .q(sec_u_s), .carry_out(sec_u_co_s)
  );
  bcd_digit_counter u_sec_t (
    .clk(clk), .reset_n(reset_n), .load(accept_s), .load_val(sync_fields_s.sec_t),
    .inc(sec_u_co_s), .max_val(BCD_MAX_TENS), .q(sec_t_s), .carry_out(sec_t_co_s)
  );
  bcd_digit_counter u_min_u (
    .clk(clk), .reset_n(reset_n), .load(accept_s), .load_val(sync_fields_s.min_u),
    .inc(sec_t_co_s), .max_val(BCD_MAX_UNITS), .q(min_u_s), .carry_out(min_u_co_s)
  );
  bcd_digit_counter u_min_t (
    .clk(clk), .reset_n(reset_n), .load(accept_s), .load_val(sync_fields_s.min_t),
    .inc(min_u_co_s), .max_val(BCD_MAX_TENS), .q(min_t_s), .carry_out(min_t_co_s)
  );
  bcd_digit_counter u_hr_u (
    .clk(clk), .reset_n(reset_n), .load(hr_load_s), .load_val(hr_u_ld_s),
    .inc(min_t_co_s), .max_val(BCD_MAX_UNITS), .q(hr_u_s), .carry_out(hr_u_co_s)
  );
  bcd_digit_counter u_hr_t (
    .clk(clk), .reset_n(reset_n), .load(hr_load_s), .load_val(hr_t_ld_s),
    .inc(hr_u_co_s), .max_val(BCD_MAX_HR_TENS), .q(hr_t_s), .carry_out(hr_t_co_unused_s)
  );

  // Reserved sync bits, incoming bit 31 and the top second-tens bit carry no information
  assign unused_bits_s = ^{tk.sync_time[VALID_BIT], tk.sync_time[RSVD_LSB +: RSVD_W],
                           sec_t_s[3], hr_t_co_unused_s};

  assign tk.time_word = {valid_r, sec_t_s[2:0], sec_u_s, 6'b000000, color_r,
                         hr_t_s, hr_u_s, min_t_s, min_u_s};
  assign tk.sec_tick  = sec_tick_r;
  assign tk.min_tick  = min_tick_r;
  assign tk.sync_ack  = sync_ack_r;
  assign tk.sync_err  = sync_err_r;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Self-checking bench for bcd_time_keeper: directed scenarios plus random
// syncs/resets, compared every cycle against a seconds-of-day reference model.
module tb_bcd_time_keeper;

  localparam int CLK_HZ = 4;
  localparam int DAY    = 86400;

  logic clk = 1'b0;
  logic reset_n;

  bcd_time_keeper_if bus();

  bcd_time_keeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .reset_n(reset_n), .tk(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_secs  = 0;
  int         m_presc = 0;
  logic [1:0] m_col   = 2'd0;
  logic       m_val   = 1'b0;
  logic       e_sec   = 1'b0;
  logic       e_min   = 1'b0;
  logic       e_ack   = 1'b0;
  logic       e_err   = 1'b0;

  function automatic logic [31:0] enc(int secs, logic [1:0] col, logic v);
    int h, m, s;
    logic [31:0] w;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    w = 32'h0000_0000;
    w[31]    = v;
    w[30:28] = 3'(s / 10);
    w[27:24] = 4'(s % 10);
    w[17:16] = col;
    w[15:12] = 4'(h / 10);
    w[11:8]  = 4'(h % 10);
    w[7:4]   = 4'(m / 10);
    w[3:0]   = 4'(m % 10);
    return w;
  endfunction

  function automatic logic sync_ok(logic [31:0] w);
    int su, stn, mu, mt, hu, ht;
    su = int'(w[27:24]); stn = int'(w[30:28]);
    mu = int'(w[3:0]);   mt  = int'(w[7:4]);
    hu = int'(w[11:8]);  ht  = int'(w[15:12]);
    return (su <= 9) && (stn <= 5) && (mu <= 9) && (mt <= 5) && (hu <= 9) &&
           (ht <= 2) && ((ht * 10 + hu) <= 23);
  endfunction

  function automatic int dec_secs(logic [31:0] w);
    int s, m, h;
    s = int'(w[30:28]) * 10 + int'(w[27:24]);
    m = int'(w[7:4])   * 10 + int'(w[3:0]);
    h = int'(w[15:12]) * 10 + int'(w[11:8]);
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic rn, input logic sv, input logic [31:0] st);
    int  old;
    logic tc;
    if (!rn) begin
      m_secs = 0; m_presc = 0; m_col = 2'd0; m_val = 1'b0;
      e_sec = 1'b0; e_min = 1'b0; e_ack = 1'b0; e_err = 1'b0;
    end else begin
      tc = (m_presc == CLK_HZ - 1);
      e_sec = 1'b0; e_min = 1'b0; e_ack = 1'b0; e_err = 1'b0;
      if (sv && sync_ok(st)) begin
        m_secs  = dec_secs(st);
        m_col   = st[17:16];
        m_val   = 1'b1;
        m_presc = 0;
        e_ack   = 1'b1;
      end else begin
        e_err = sv;
        if (tc) begin
          old     = m_secs;
          m_secs  = (m_secs + 1) % DAY;
          e_sec   = 1'b1;
          e_min   = ((old / 60) != (m_secs / 60));
          m_presc = 0;
        end else begin
          m_presc = m_presc + 1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare all outputs
  task automatic step(input logic rn, input logic sv, input logic [31:0] st);
    reset_n        = rn;
    bus.sync_valid = sv;
    bus.sync_time  = st;
    @(posedge clk);
    model_update(rn, sv, st);
    #1;
    chk("model_word",     bus.time_word,          enc(m_secs, m_col, m_val));
    chk("model_sec_tick", {31'b0, bus.sec_tick},  {31'b0, e_sec});
    chk("model_min_tick", {31'b0, bus.min_tick},  {31'b0, e_min});
    chk("model_sync_ack", {31'b0, bus.sync_ack},  {31'b0, e_ack});
    chk("model_sync_err", {31'b0, bus.sync_err},  {31'b0, e_err});
  endtask

  initial begin
    int          mt_cnt;
    int          r;
    logic        sv;
    logic        rn;
    logic [31:0] w;

    // 1: reset, then free-run 12 cycles
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("reset_word", bus.time_word, 32'h0000_0000);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("run_sec_tick", {31'b0, bus.sec_tick}, ((i % 4) == 3) ? 32'd1 : 32'd0);
    end
    chk("run_word", bus.time_word, 32'h0300_0000);

    // 2: sync 12:59:23 colour 2, then 37 seconds to 13:00:00
    step(1'b1, 1'b1, 32'h2302_1259);
    chk("sync_word", bus.time_word, 32'hA302_1259);
    chk("sync_ack",  {31'b0, bus.sync_ack}, 32'd1);
    mt_cnt = 0;
    for (int i = 0; i < 37 * CLK_HZ; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (bus.min_tick) mt_cnt++;
    end
    chk("hour_turn_word", bus.time_word, 32'h8002_1300);
    chk("hour_turn_min_ticks", mt_cnt, 32'd1);

    // 3: midnight rollover keeps colour
    step(1'b1, 1'b1, 32'h5901_2359);
    chk("pre_midnight_word", bus.time_word, 32'hD901_2359);
    for (int i = 0; i < CLK_HZ; i++) step(1'b1, 1'b0, 32'h0);
    chk("midnight_word",     bus.time_word, 32'h8001_0000);
    chk("midnight_sec_tick", {31'b0, bus.sec_tick}, 32'd1);
    chk("midnight_min_tick", {31'b0, bus.min_tick}, 32'd1);

    // 4: bad minute tens, then hours 24
    step(1'b1, 1'b1, 32'h0003_1260);
    chk("bad_min_err", {31'b0, bus.sync_err}, 32'd1);
    chk("bad_min_ack", {31'b0, bus.sync_ack}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_2400);
    chk("bad_hour_err", {31'b0, bus.sync_err}, 32'd1);
    chk("bad_hour_ack", {31'b0, bus.sync_ack}, 32'd0);
    chk("bad_hour_word_hours", {24'b0, bus.time_word[15:8]}, 32'h0000_0000);

    // 5: sync coincident with terminal count
    for (int i = 0; i < 2 * CLK_HZ && m_presc != CLK_HZ - 1; i++) step(1'b1, 1'b0, 32'h0);
    chk("tc_aligned", m_presc, CLK_HZ - 1);
    step(1'b1, 1'b1, 32'h1234_0745);
    chk("tc_sync_word",     bus.time_word, 32'h9200_0745);
    chk("tc_sync_sec_tick", {31'b0, bus.sec_tick}, 32'd0);
    for (int i = 0; i < CLK_HZ; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("tc_next_tick", {31'b0, bus.sec_tick}, (i == CLK_HZ - 1) ? 32'd1 : 32'd0);
    end
    chk("tc_next_word", bus.time_word, 32'h9300_0745);

    // 6: one-cycle reset mid-count
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("mid_reset_word",   bus.time_word, 32'h0000_0000);
    chk("mid_reset_pulses", {28'b0, bus.sec_tick, bus.min_tick, bus.sync_ack, bus.sync_err}, 32'd0);

    // Back-to-back syncs: valid, invalid, valid
    step(1'b1, 1'b1, 32'h4503_0958);
    step(1'b1, 1'b1, 32'h0000_0070);
    step(1'b1, 1'b1, 32'h0101_2200);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      r  = int'($urandom_range(0, 199));
      rn = (r != 0);
      sv = (r >= 170);
      w  = 32'h0;
      if (sv) begin
        if ($urandom_range(0, 1) == 1) begin
          w = enc(int'($urandom_range(0, DAY - 1)), 2'($urandom_range(0, 3)), 1'b0);
          w[23:18] = 6'($urandom_range(0, 63));
          w[31]    = 1'($urandom_range(0, 1));
        end else begin
          w = $urandom;
        end
      end
      step(rn, sv, w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
